run_ctrl: RTL
=============

RUN_CTRL -- requirements
Module: run_ctrl

Interface
REQ-001 Parameter DUMP_BASE, 8, first data-memory address read back after the run.
REQ-002 Parameter DUMP_LEN, 4, number of result bytes read back (1..256).
REQ-003 Parameter START_HOLD, 2, cycles dut_start stays high after loading, before release (>=1).
REQ-004 Parameter TIMEOUT_CYCLES, 4096, maximum RUN cycles when the timeout is compiled in.
REQ-005 CLK  in  1  sole clock, all state on rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 go  in  1  single-cycle request to begin a clear/load/run/dump sequence.
REQ-008 ld_valid / ld_ready  in / out  1 / 1  load-stream handshake.
REQ-009 ld_addr, ld_data  in  8, 8  data-memory byte to preload.
REQ-010 ld_last  in  1  marks the final load beat.
REQ-011 dut_start  out  1  drives DUT start; high holds DUT in reset.
REQ-012 dut_halt  in  1  DUT done flag.
REQ-013 mem_addr, mem_wr_data  out  8, 8  DUT data-memory port.
REQ-014 mem_wr_en  out  1  write strobe to DUT data memory.
REQ-015 mem_rd_data  in  8  asynchronous read data for mem_addr.
REQ-016 res_valid / res_ready  out / in  1 / 1  result-stream handshake.
REQ-017 res_addr, res_data  out  8, 8  address and byte of the current result.
REQ-018 busy, done, timeout  out  1  status; done is a one-cycle pulse.
REQ-019 run_cycles  out  16  count of RUN cycles, saturating at 16'hFFFF.

Function
REQ-020 States IDLE, CLEAR, LOAD, START, RUN, DUMP, DONE; one-hot or binary at implementer's choice.
REQ-021 IDLE: go=1 -> CLEAR, clear run_cycles and timeout; go in any other state ignored.
REQ-022 CLEAR: 256 cycles, mem_wr_en=1, mem_addr 0..255, mem_wr_data=0; after address 255 -> LOAD.
REQ-023 LOAD: ld_ready=1; beat on ld_valid&&ld_ready writes ld_data to ld_addr same cycle; beat with ld_last -> START.
REQ-024 ld_ready=0 outside LOAD; ld_valid outside LOAD has no effect.
REQ-025 START: dut_start=1 for START_HOLD cycles, then -> RUN.
REQ-026 dut_start=1 in IDLE, CLEAR, LOAD, START and DONE; 0 only in RUN and DUMP.
REQ-027 RUN: run_cycles increments every cycle; dut_halt ignored on first RUN cycle, sampled thereafter; dut_halt=1 -> DUMP.
REQ-028 DUMP: mem_addr = DUMP_BASE + index (mod 256 wrap); res_valid=1; res_addr=mem_addr; res_data=mem_rd_data.
REQ-029 DUMP: index advances on res_valid&&res_ready; accepted beat index DUMP_LEN-1 -> DONE; res_valid=0 else.
REQ-030 DONE: done=1 one cycle, -> IDLE; go in DONE ignored.
REQ-031 mem_wr_en=1 only in CLEAR and on LOAD beats; never in DUMP.
REQ-032 busy=1 in every state except IDLE.

Reset
REQ-033 reset=1 at a rising edge -> IDLE from any state, incl. mid-CLEAR/LOAD/RUN/DUMP.
REQ-034 Reset values: dut_start=1, mem_wr_en=0, ld_ready=0, res_valid=0, done=0, busy=0, timeout=0, run_cycles=0, mem_addr=0, mem_wr_data=0.
REQ-035 reset has priority over go; a partially drained dump is abandoned.

Configuration
REQ-036 Macro RUN_CTRL_TIMEOUT_EN defined: RUN exits to DUMP with timeout=1 when run_cycles reaches TIMEOUT_CYCLES without dut_halt; timeout holds until next go or reset.
REQ-037 Macro absent: RUN waits for dut_halt indefinitely; timeout tied 0; no timeout comparator present.

Verification
REQ-038 reset, go, load {9:8'h70, last at 11:8'h00}, halt 20 cycles after release -> memory 0 except 9=70; res stream (8,00),(9,70),(10,00),(11,00); done pulse.
REQ-039 res_ready low 3 cycles mid-dump -> res_valid/res_addr/res_data stable; no beat lost or duplicated.
REQ-040 dut_halt held 1 throughout START and first RUN cycle -> dut_start drop observed, DUMP entered on second RUN cycle, run_cycles=2.
REQ-041 reset asserted during CLEAR at address 100 -> next cycle IDLE, mem_wr_en=0, dut_start=1; go restarts at address 0.
REQ-042 DUMP_BASE=254, DUMP_LEN=4 -> res_addr 254,255,0,1.
REQ-043 With RUN_CTRL_TIMEOUT_EN, TIMEOUT_CYCLES=50, no halt -> timeout=1, run_cycles=50, dump proceeds; without macro -> stays in RUN, busy=1.

Source files
------------

// File: rtl/run_ctrl_if.sv
// Bundle of run_ctrl control, load, DUT-memory and result signals.
// master = run_ctrl side, slave = environment (loader, DUT, memory, result sink).
interface run_ctrl_if;
  logic        go;
  logic        ld_valid;
  logic        ld_ready;
  logic [7:0]  ld_addr;
  logic [7:0]  ld_data;
  logic        ld_last;
  logic        dut_start;
  logic        dut_halt;
  logic [7:0]  mem_addr;
  logic [7:0]  mem_wr_data;
  logic        mem_wr_en;
  logic [7:0]  mem_rd_data;
  logic        res_valid;
  logic        res_ready;
  logic [7:0]  res_addr;
  logic [7:0]  res_data;
  logic        busy;
  logic        done;
  logic        timeout;
  logic [15:0] run_cycles;

  modport master (
    input  go, ld_valid, ld_addr, ld_data, ld_last, dut_halt, mem_rd_data, res_ready,
    output ld_ready, dut_start, mem_addr, mem_wr_data, mem_wr_en,
           res_valid, res_addr, res_data, busy, done, timeout, run_cycles
  );

  modport slave (
    output go, ld_valid, ld_addr, ld_data, ld_last, dut_halt, mem_rd_data, res_ready,
    input  ld_ready, dut_start, mem_addr, mem_wr_data, mem_wr_en,
           res_valid, res_addr, res_data, busy, done, timeout, run_cycles
  );
endinterface

// File: rtl/run_ctrl.sv
// Clear/load/run/dump sequencer around a DUT data memory.
// Optional RUN timeout is compiled in with `define RUN_CTRL_TIMEOUT_EN.
module run_ctrl #(
  parameter int DUMP_BASE      = 8,
  parameter int DUMP_LEN       = 4,
  parameter int START_HOLD     = 2,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic      clk,
  input  logic      reset,
  run_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_LOAD, S_START, S_RUN, S_DUMP, S_DONE
  } state_t;

  localparam logic [7:0]  BASE8     = 8'(DUMP_BASE);
  localparam logic [7:0]  LAST_IDX  = 8'(DUMP_LEN - 1);
  localparam logic [15:0] HOLD_LAST = 16'(START_HOLD - 1);

  if (START_HOLD < 1 || DUMP_LEN < 1 || DUMP_LEN > 256 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("run_ctrl: parameter out of range");
  end

  state_t      state, nstate;
  logic [15:0] cnt;          // clear address, start-hold count, run first-cycle flag, dump index
  logic [15:0] run_cycles_q;
  logic        first_run;
  logic        halt_ok;
  logic        to_hit;
  logic        beat_ld;
  logic        beat_res;

  assign first_run = (cnt == 16'd0);
  assign halt_ok   = !first_run && bus.dut_halt;
  assign beat_ld   = (state == S_LOAD) && bus.ld_valid;
  assign beat_res  = (state == S_DUMP) && bus.res_ready;

`ifdef RUN_CTRL_TIMEOUT_EN
  logic timeout_q;
  assign to_hit = (run_cycles_q == 16'(TIMEOUT_CYCLES - 1));
`else
  assign to_hit = 1'b0;
`endif

  // state register
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= nstate;
  end

  // next-state logic
  always_comb begin
    nstate = state;
    case (state)
      S_IDLE:  if (bus.go) nstate = S_CLEAR;
      S_CLEAR: if (cnt[7:0] == 8'hFF) nstate = S_LOAD;
      S_LOAD:  if (beat_ld && bus.ld_last) nstate = S_START;
      S_START: if (cnt == HOLD_LAST) nstate = S_RUN;
      S_RUN:   if (halt_ok || to_hit) nstate = S_DUMP;
      S_DUMP:  if (beat_res && cnt[7:0] == LAST_IDX) nstate = S_DONE;
      S_DONE:  nstate = S_IDLE;
      default: nstate = S_IDLE;
    endcase
  end

  // cnt restarts on every state change so each state sees its own index from 0
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= 16'd0;
    end else if (nstate != state) begin
      cnt <= 16'd0;
    end else begin
      case (state)
        S_CLEAR, S_START: cnt <= cnt + 16'd1;
        S_RUN:            cnt <= 16'd1;
        S_DUMP:           if (beat_res) cnt <= cnt + 16'd1;
        default:          cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      run_cycles_q <= 16'd0;
    end else if (state == S_IDLE && bus.go) begin
      run_cycles_q <= 16'd0;
    end else if (state == S_RUN && run_cycles_q != 16'hFFFF) begin
      run_cycles_q <= run_cycles_q + 16'd1;
    end
  end

`ifdef RUN_CTRL_TIMEOUT_EN
  // a halt seen in the same cycle as the limit wins; timeout only flags a real expiry
  always_ff @(posedge clk) begin
    if (reset)                           timeout_q <= 1'b0;
    else if (state == S_IDLE && bus.go)  timeout_q <= 1'b0;
    else if (state == S_RUN && to_hit && !halt_ok) timeout_q <= 1'b1;
  end
  assign bus.timeout = timeout_q;
`else
  assign bus.timeout = 1'b0;
`endif

  assign bus.run_cycles = run_cycles_q;

  // output decode
  always_comb begin
    bus.ld_ready    = 1'b0;
    bus.dut_start   = 1'b1;
    bus.mem_addr    = 8'd0;
    bus.mem_wr_data = 8'd0;
    bus.mem_wr_en   = 1'b0;
    bus.res_valid   = 1'b0;
    bus.res_addr    = 8'd0;
    bus.res_data    = 8'd0;
    bus.busy        = 1'b1;
    bus.done        = 1'b0;
    case (state)
      S_IDLE:  bus.busy = 1'b0;
      S_CLEAR: begin
        bus.mem_wr_en = 1'b1;
        bus.mem_addr  = cnt[7:0];
      end
      S_LOAD: begin
        bus.ld_ready    = 1'b1;
        bus.mem_wr_en   = bus.ld_valid;
        bus.mem_addr    = bus.ld_addr;
        bus.mem_wr_data = bus.ld_data;
      end
      S_START: ;
      S_RUN:   bus.dut_start = 1'b0;
      S_DUMP: begin
        bus.dut_start = 1'b0;
        bus.mem_addr  = BASE8 + cnt[7:0];
        bus.res_valid = 1'b1;
        bus.res_addr  = BASE8 + cnt[7:0];
        bus.res_data  = bus.mem_rd_data;
      end
      S_DONE:  bus.done = 1'b1;
      default: ;
    endcase
  end

`ifndef SYNTHESIS
  a_no_wr_in_dump: assert property (@(posedge clk) disable iff (reset)
    (state == S_DUMP) |-> !bus.mem_wr_en);
  a_done_pulse:    assert property (@(posedge clk) disable iff (reset)
    bus.done |=> !bus.done);
  a_start_low:     assert property (@(posedge clk) disable iff (reset)
    !bus.dut_start |-> (state == S_RUN || state == S_DUMP));
`endif

endmodule
